// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N one-hot decoder with LEVEL, PULSE (fixed-length strobe)
// and SCAN (rotating sweep) modes. All outputs come straight from flops.
//
// state | meaning
// IDLE  | no timed activity; y is either a LEVEL decode or off
// PULSE | strobe active, cnt counts the remaining hold edges
// SCAN  | rotating one-hot, index advances every enabled edge
module decoder_seq_n #(
  parameter int N         = 3,
  parameter int PULSE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [N-1:0]      a,
  output logic [2**N-1:0]   y,
  output logic              busy,
  output logic [N-1:0]      idx
);

  localparam int OW = 2**N;
  localparam int CW = $clog2(PULSE_LEN) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN - 1);

  localparam logic [1:0] M_LEVEL = 2'b00;
  localparam logic [1:0] M_PULSE = 2'b01;
  localparam logic [1:0] M_SCAN  = 2'b10;

  typedef enum logic [1:0] {IDLE, PULSE, SCAN} state_t;

  state_t          state_q, state_d, state_eff;
  logic [OW-1:0]   y_q, y_d;
  logic [N-1:0]    idx_q, idx_d, idx_inc;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [OW-1:0] onehot(input logic [N-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    // A busy state only survives while the mode that owns it is still selected;
    // otherwise the new mode's rules are applied as if starting from IDLE.
    state_eff = state_q;
    if (state_q == PULSE && mode != M_PULSE) state_eff = IDLE;
    if (state_q == SCAN  && mode != M_SCAN)  state_eff = IDLE;

    if (!en) begin
      y_d     = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (mode)
        M_LEVEL: begin
          idx_d   = a;
          y_d     = onehot(a);
          state_d = IDLE;
          cnt_d   = '0;
        end
        M_PULSE: begin
          if (load) begin
            idx_d   = a;
            y_d     = onehot(a);
            cnt_d   = CNT_LOAD;
            state_d = PULSE;
          end else if (state_eff == PULSE) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              y_d     = '0;
              state_d = IDLE;
            end
          end else begin
            y_d     = '0;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        M_SCAN: begin
          cnt_d = '0;
          if (load) begin
            idx_d   = a;
            y_d     = onehot(a);
            state_d = SCAN;
          end else if (state_eff == SCAN) begin
            idx_d = idx_inc;
            y_d   = onehot(idx_inc);
          end else begin
            y_d     = '0;
            state_d = IDLE;
          end
        end
        default: begin
          y_d     = '0;
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign busy = (state_q != IDLE);

endmodule
